stream_data_memory: RTL and testbench
=====================================

# stream_data_memory

Parametrised two-port data memory that extends the processor data RAM with lane-masked writes, registered read-valid signalling and an autonomous burst-read channel for the display path. Port A serves the CPU datapath with single-cycle read/write requests. Port B replaces the free-running VGA address port with a start/length streaming engine that has ready/valid backpressure, so the display pipeline can fetch frame data without supplying an address every cycle.

## Interface
- DATA_WIDTH, 64: word width; must be a multiple of LANE_WIDTH
- ADDR_WIDTH, 10: word address width; depth = 2**ADDR_WIDTH
- LANE_WIDTH, 8: bits per write lane; LANES = DATA_WIDTH/LANE_WIDTH
- clk  in  1  single clock; all logic on posedge
- rst  in  1  synchronous, active-high reset
- a_req  in  1  port A request, sampled each edge; always accepted (no stall)
- a_we  in  1  1 = write, 0 = read
- a_lane_en  in  LANES  per-lane write enable; ignored for reads
- a_addr  in  ADDR_WIDTH  word address
- a_wdata  in  DATA_WIDTH  write data
- a_rdata  out  DATA_WIDTH  read data, registered
- a_rvalid  out  1  a_rdata holds read result (one-cycle pulse per read)
- b_start  in  1  start burst; honoured only when b_busy = 0
- b_abort  in  1  cancel burst
- b_base  in  ADDR_WIDTH  burst start address, latched on accepted start
- b_len  in  ADDR_WIDTH  beats in burst; 0 means 2**ADDR_WIDTH beats
- b_ready  in  1  consumer accepts b_data this cycle
- b_data  out  DATA_WIDTH  burst beat data
- b_valid  out  1  b_data valid
- b_last  out  1  current beat is final beat of burst
- b_busy  out  1  burst in progress (IDLE = 0)

## Operation
- Reset: a_rdata = 0, a_rvalid = 0, b_data = 0, b_valid = 0, b_last = 0, b_busy = 0, FSM = IDLE, pointer/counter = 0. RAM contents not reset.
- Port A write: a_req & a_we at edge → each lane i with a_lane_en[i] = 1 updated from a_wdata; others unchanged. a_rvalid = 0 next cycle.
- Port A read: a_req & !a_we at edge → a_rdata = ram[a_addr], a_rvalid = 1 for one cycle. No request → a_rvalid = 0, a_rdata holds.
- Port B FSM states IDLE, STREAM.
  - IDLE: b_start at edge → latch ptr = b_base, remaining = (b_len == 0 ? 2**ADDR_WIDTH : b_len), go STREAM, b_busy = 1.
  - STREAM: fetch slot free when (!b_valid | b_ready). If slot free and remaining > 0: b_data = ram[ptr], b_valid = 1, b_last = (remaining == 1), ptr = ptr + 1 mod 2**ADDR_WIDTH, remaining − 1. If slot free and remaining = 0: b_valid = 0, b_last = 0, go IDLE, b_busy = 0.
  - b_valid & !b_ready: b_data, b_last, ptr, remaining all hold.
- remaining counter is ADDR_WIDTH+1 bits to represent full depth.
- Address wrap: ptr past 2**ADDR_WIDTH−1 wraps to 0 silently.
- b_abort (any state) at edge: b_valid = 0, b_last = 0, go IDLE, b_busy = 0; has priority over b_start and fetch.
- b_start while b_busy = 1 ignored.
- rst mid-burst: identical to reset values; burst lost.

## Timing
- Port A read latency 1 cycle; throughput 1 request/cycle.
- b_start sampled at edge E0 → b_busy high after E0; first b_valid after E1.
- With b_ready held high: one beat per cycle; N-beat burst occupies b_valid for N consecutive cycles; b_busy falls the edge after the last beat is accepted.
- Next b_start accepted earliest on the edge where b_busy is already 0.

## Configuration
- DATAMEM_WR_FORWARD_EN defined: when a port B fetch and a port A write hit the same address on the same edge, b_data returns the lane-merged new word (write-first).
- Not defined: b_data returns the word as it was before that write (read-first); the write still lands.

## Test plan
- Write 0x1122334455667788 to addr 5 with a_lane_en = 0xFF, then a_lane_en = 0x01 with wdata 0xAA; read addr 5 → a_rdata = 0x11223344556677AA, a_rvalid one cycle after request.
- Preload addr k with value k; b_base = 3, b_len = 4, b_ready = 1 → beats 3,4,5,6 on consecutive cycles, b_last only on 6, b_busy low after.
- ADDR_WIDTH = 4, b_base = 14, b_len = 4 → beats 14,15,0,1; b_len = 0 → 16 beats starting at b_base.
- Same burst with b_ready low for 3 cycles mid-burst → b_data/b_last held stable, no beat skipped or duplicated.
- Assert b_abort after 2 beats, and separately rst mid-burst → b_valid, b_busy = 0 next cycle; new b_start then runs a clean burst.
- Port A write of 0xFF..FF to addr 8 on the edge port B fetches addr 8 → b_data = 0xFF..FF with DATAMEM_WR_FORWARD_EN, old content without.

Source files
------------

// File: rtl/stream_data_memory.sv
// stream_data_memory: two-port data RAM with a CPU port and a display burst port.
// Port A is a single-cycle read/write port with per-lane write enables and a registered
// read-valid pulse. Port B is a start/length burst reader with ready/valid backpressure.
// Optional feature macro: DATAMEM_WR_FORWARD_EN. When defined, a port B fetch that hits
// the address of a simultaneous port A write returns the merged new word (write-first).
// When not defined, the fetch returns the old word (read-first).

module stream_data_memory #(
    parameter int unsigned DATA_WIDTH = 64,
    parameter int unsigned ADDR_WIDTH = 10,
    parameter int unsigned LANE_WIDTH = 8
) (
    input  logic                               clk,
    input  logic                               rst,
    input  logic                               a_req,
    input  logic                               a_we,
    input  logic [DATA_WIDTH/LANE_WIDTH-1:0]   a_lane_en,
    input  logic [ADDR_WIDTH-1:0]              a_addr,
    input  logic [DATA_WIDTH-1:0]              a_wdata,
    output logic [DATA_WIDTH-1:0]              a_rdata,
    output logic                               a_rvalid,
    input  logic                               b_start,
    input  logic                               b_abort,
    input  logic [ADDR_WIDTH-1:0]              b_base,
    input  logic [ADDR_WIDTH-1:0]              b_len,
    input  logic                               b_ready,
    output logic [DATA_WIDTH-1:0]              b_data,
    output logic                               b_valid,
    output logic                               b_last,
    output logic                               b_busy
);

    localparam int unsigned LANES = DATA_WIDTH / LANE_WIDTH;
    localparam int unsigned DEPTH = 2 ** ADDR_WIDTH;
    // A length of zero encodes a full-depth burst, hence the extra counter bit.
    localparam logic [ADDR_WIDTH:0] FULL_LEN = {1'b1, {ADDR_WIDTH{1'b0}}};
    localparam logic [ADDR_WIDTH:0] ONE_LEFT = {{ADDR_WIDTH{1'b0}}, 1'b1};

    typedef enum logic [0:0] {StIdle, StStream} state_e;

    logic [DATA_WIDTH-1:0] mem [DEPTH];

    logic [DATA_WIDTH-1:0] a_rdata_q;
    logic                  a_rvalid_q;

    state_e                state_q, state_d;
    logic [ADDR_WIDTH-1:0] ptr_q, ptr_d;
    logic [ADDR_WIDTH:0]   rem_q, rem_d;
    logic [DATA_WIDTH-1:0] b_data_q, b_data_d;
    logic                  b_valid_q, b_valid_d;
    logic                  b_last_q, b_last_d;
    logic                  slot_free;
    logic [DATA_WIDTH-1:0] fetch_word;

    // Lane-masked RAM write from port A; contents are deliberately not reset.
    always_ff @(posedge clk) begin
        if (a_req && a_we) begin
            for (int i = 0; i < LANES; i++) begin
                if (a_lane_en[i]) begin
                    mem[a_addr][i*LANE_WIDTH +: LANE_WIDTH] <= a_wdata[i*LANE_WIDTH +: LANE_WIDTH];
                end
            end
        end
    end

    // Port A registered read data and one-cycle read-valid pulse.
    always_ff @(posedge clk) begin
        if (rst) begin
            a_rdata_q  <= '0;
            a_rvalid_q <= 1'b0;
        end else begin
            a_rvalid_q <= a_req & ~a_we;
            if (a_req && !a_we) begin
                a_rdata_q <= mem[a_addr];
            end
        end
    end

`ifdef DATAMEM_WR_FORWARD_EN
    logic [DATA_WIDTH-1:0] a_merged;

    // New word as it will look after this edge's port A write.
    always_comb begin
        a_merged = mem[a_addr];
        for (int i = 0; i < LANES; i++) begin
            if (a_lane_en[i]) begin
                a_merged[i*LANE_WIDTH +: LANE_WIDTH] = a_wdata[i*LANE_WIDTH +: LANE_WIDTH];
            end
        end
    end

    assign fetch_word = (a_req && a_we && (a_addr == ptr_q)) ? a_merged : mem[ptr_q];
`else
    assign fetch_word = mem[ptr_q];
`endif

    assign slot_free = ~b_valid_q | b_ready;

    // Burst FSM state register.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= StIdle;
        end else begin
            state_q <= state_d;
        end
    end

    // Burst FSM next state; abort overrides everything.
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            StIdle:   if (b_start) state_d = StStream;
            StStream: if (slot_free && (rem_q == '0)) state_d = StIdle;
            default:  state_d = StIdle;
        endcase
        if (b_abort) begin
            state_d = StIdle;
        end
    end

    // Burst outputs and datapath next values (pointer, counter, output slot).
    always_comb begin
        b_busy    = (state_q == StStream);
        ptr_d     = ptr_q;
        rem_d     = rem_q;
        b_data_d  = b_data_q;
        b_valid_d = b_valid_q;
        b_last_d  = b_last_q;
        if (b_abort) begin
            b_valid_d = 1'b0;
            b_last_d  = 1'b0;
        end else if (state_q == StIdle) begin
            if (b_start) begin
                ptr_d = b_base;
                rem_d = (b_len == '0) ? FULL_LEN : {1'b0, b_len};
            end
        end else if (slot_free) begin
            if (rem_q != '0) begin
                b_data_d  = fetch_word;
                b_valid_d = 1'b1;
                b_last_d  = (rem_q == ONE_LEFT);
                ptr_d     = ptr_q + ADDR_WIDTH'(1);
                rem_d     = rem_q - ONE_LEFT;
            end else begin
                b_valid_d = 1'b0;
                b_last_d  = 1'b0;
            end
        end
    end

    // Burst datapath registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            ptr_q     <= '0;
            rem_q     <= '0;
            b_data_q  <= '0;
            b_valid_q <= 1'b0;
            b_last_q  <= 1'b0;
        end else begin
            ptr_q     <= ptr_d;
            rem_q     <= rem_d;
            b_data_q  <= b_data_d;
            b_valid_q <= b_valid_d;
            b_last_q  <= b_last_d;
        end
    end

    assign a_rdata  = a_rdata_q;
    assign a_rvalid = a_rvalid_q;
    assign b_data   = b_data_q;
    assign b_valid  = b_valid_q;
    assign b_last   = b_last_q;

endmodule

// File: tb/tb_stream_data_memory.sv
// Directed bench for stream_data_memory (ADDR_WIDTH = 4 so wrap and full-depth bursts are short).
// Expected burst beats go into a scoreboard queue when a burst is started and are popped by a
// negedge monitor on every accepted beat; the monitor also checks stalled beats stay stable.

module tb_stream_data_memory;

    localparam int DW = 64;
    localparam int AW = 4;

    typedef struct packed {
        logic [DW-1:0] d;
        logic          l;
    } beat_t;

    logic          clk;
    logic          rst;
    logic          a_req;
    logic          a_we;
    logic [7:0]    a_lane_en;
    logic [AW-1:0] a_addr;
    logic [DW-1:0] a_wdata;
    logic [DW-1:0] a_rdata;
    logic          a_rvalid;
    logic          b_start;
    logic          b_abort;
    logic [AW-1:0] b_base;
    logic [AW-1:0] b_len;
    logic          b_ready;
    logic [DW-1:0] b_data;
    logic          b_valid;
    logic          b_last;
    logic          b_busy;

    int            checks = 0;
    int            errors = 0;
    logic          mon_en = 1'b0;
    beat_t         b_q[$];
    logic [DW-1:0] a_q[$];

    stream_data_memory #(
        .DATA_WIDTH (DW),
        .ADDR_WIDTH (AW),
        .LANE_WIDTH (8)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .a_req     (a_req),
        .a_we      (a_we),
        .a_lane_en (a_lane_en),
        .a_addr    (a_addr),
        .a_wdata   (a_wdata),
        .a_rdata   (a_rdata),
        .a_rvalid  (a_rvalid),
        .b_start   (b_start),
        .b_abort   (b_abort),
        .b_base    (b_base),
        .b_len     (b_len),
        .b_ready   (b_ready),
        .b_data    (b_data),
        .b_valid   (b_valid),
        .b_last    (b_last),
        .b_busy    (b_busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [DW-1:0] obs, input logic [DW-1:0] exp_v);
        checks++;
        assert (obs === exp_v) else begin
            errors++;
            $error("FAIL %s: observed=%h expected=%h", tag, obs, exp_v);
        end
    endtask

    task automatic check_bit(input string tag, input logic obs, input logic exp_v);
        checks++;
        assert (obs === exp_v) else begin
            errors++;
            $error("FAIL %s: observed=%b expected=%b", tag, obs, exp_v);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic wr(input int addr, input logic [7:0] en, input logic [DW-1:0] data);
        a_req     = 1'b1;
        a_we      = 1'b1;
        a_addr    = AW'(addr);
        a_lane_en = en;
        a_wdata   = data;
        step();
        a_req = 1'b0;
        a_we  = 1'b0;
        check_bit("a_rvalid_after_write", a_rvalid, 1'b0);
    endtask

    task automatic rd(input int addr, input logic [DW-1:0] exp_v);
        a_req  = 1'b1;
        a_we   = 1'b0;
        a_addr = AW'(addr);
        a_q.push_back(exp_v);
        step();
        a_req = 1'b0;
        check_bit("a_rvalid_read", a_rvalid, 1'b1);
        check("a_rdata", a_rdata, a_q.pop_front());
        step();
        check_bit("a_rvalid_pulse", a_rvalid, 1'b0);
    endtask

    task automatic push_beats(input int base, input int n, input int total);
        for (int i = 0; i < n; i++) begin
            beat_t bt;
            bt.d = DW'((base + i) % 16);
            bt.l = (i == total - 1);
            b_q.push_back(bt);
        end
    endtask

    // Wait (bounded) for b_busy to drop; returns the number of edges waited.
    task automatic wait_idle(output int cyc);
        cyc = 0;
        while (b_busy === 1'b1 && cyc < 200) begin
            step();
            cyc++;
        end
        check_bit("burst_terminates", (cyc < 200), 1'b1);
    endtask

    task automatic run_burst(input int base, input int len, input int stall_at,
                             input int stall_len, input bit poke);
        int n = (len == 0) ? 16 : len;
        int cyc = 0;
        push_beats(base, n, n);
        b_base  = AW'(base);
        b_len   = AW'(len);
        b_start = 1'b1;
        step();
        b_start = 1'b0;
        check_bit("b_busy_after_start", b_busy, 1'b1);
        while (b_busy === 1'b1 && cyc < 200) begin
            if (cyc == stall_at) b_ready = 1'b0;
            if (cyc == stall_at + stall_len) b_ready = 1'b1;
            if (poke && cyc == 1) begin
                // Start while busy must be ignored.
                b_start = 1'b1;
                b_base  = 4'd9;
                b_len   = 4'd2;
            end else begin
                b_start = 1'b0;
            end
            step();
            cyc++;
        end
        b_start = 1'b0;
        b_ready = 1'b1;
        check("burst_cycles", DW'(cyc), DW'(n + 1 + stall_len));
        check("burst_beats_left", DW'(b_q.size()), DW'(0));
        check_bit("b_valid_after_burst", b_valid, 1'b0);
    endtask

    // Scoreboard monitor: compare accepted beats and check stalled beats hold.
    initial begin
        beat_t held;
        beat_t exp_b;
        logic  hold_pending;
        hold_pending = 1'b0;
        held = '0;
        forever begin
            @(negedge clk);
            if (mon_en) begin
                if (hold_pending) begin
                    check_bit("b_hold_valid", b_valid, 1'b1);
                    check("b_hold_data", b_data, held.d);
                    check_bit("b_hold_last", b_last, held.l);
                end
                if (b_valid === 1'b1 && b_ready === 1'b1) begin
                    check_bit("b_beat_expected", (b_q.size() != 0), 1'b1);
                    if (b_q.size() != 0) begin
                        exp_b = b_q.pop_front();
                        check("b_data", b_data, exp_b.d);
                        check_bit("b_last", b_last, exp_b.l);
                    end
                end
                hold_pending = (b_valid === 1'b1) && (b_ready === 1'b0);
                held.d = b_data;
                held.l = b_last;
            end
        end
    end

    initial begin
        int cyc;
        logic [DW-1:0] fwd_exp;
        beat_t bt;

        rst       = 1'b1;
        a_req     = 1'b0;
        a_we      = 1'b0;
        a_lane_en = '0;
        a_addr    = '0;
        a_wdata   = '0;
        b_start   = 1'b0;
        b_abort   = 1'b0;
        b_base    = '0;
        b_len     = '0;
        b_ready   = 1'b1;
        step();
        step();
        check("rst_a_rdata", a_rdata, '0);
        check_bit("rst_a_rvalid", a_rvalid, 1'b0);
        check("rst_b_data", b_data, '0);
        check_bit("rst_b_valid", b_valid, 1'b0);
        check_bit("rst_b_last", b_last, 1'b0);
        check_bit("rst_b_busy", b_busy, 1'b0);
        rst    = 1'b0;
        mon_en = 1'b1;

        // Lane-masked write then read back.
        wr(5, 8'hFF, 64'h1122334455667788);
        wr(5, 8'h01, 64'h00000000000000AA);
        rd(5, 64'h11223344556677AA);
        wr(5, 8'h0C, 64'h0000_0000_BEEF_0000);
        rd(5, 64'h11223344BEEF77AA);

        // Preload addr k with value k.
        for (int k = 0; k < 16; k++) wr(k, 8'hFF, DW'(k));
        rd(9, 64'd9);

        run_burst(3, 4, -1, 0, 1'b0);
        run_burst(14, 4, -1, 0, 1'b1);
        run_burst(5, 0, -1, 0, 1'b0);
        run_burst(14, 4, 2, 3, 1'b0);

        // Abort after two accepted beats.
        push_beats(0, 2, 8);
        b_base  = 4'd0;
        b_len   = 4'd8;
        b_start = 1'b1;
        step();
        b_start = 1'b0;
        step();
        step();
        b_abort = 1'b1;
        step();
        b_abort = 1'b0;
        check_bit("abort_b_valid", b_valid, 1'b0);
        check_bit("abort_b_busy", b_busy, 1'b0);
        check_bit("abort_b_last", b_last, 1'b0);
        check("abort_beats_left", DW'(b_q.size()), DW'(0));
        run_burst(3, 4, -1, 0, 1'b0);

        // Reset mid-burst.
        push_beats(0, 2, 8);
        b_base  = 4'd0;
        b_len   = 4'd8;
        b_start = 1'b1;
        step();
        b_start = 1'b0;
        step();
        step();
        rst = 1'b1;
        step();
        rst = 1'b0;
        check_bit("rstmid_b_valid", b_valid, 1'b0);
        check_bit("rstmid_b_busy", b_busy, 1'b0);
        check_bit("rstmid_b_last", b_last, 1'b0);
        check("rstmid_b_data", b_data, '0);
        check("rstmid_beats_left", DW'(b_q.size()), DW'(0));
        run_burst(0, 4, -1, 0, 1'b0);

        // Same-edge port A write and port B fetch of addr 8.
`ifdef DATAMEM_WR_FORWARD_EN
        fwd_exp = '1;
`else
        fwd_exp = 64'd8;
`endif
        bt.d = fwd_exp;
        bt.l = 1'b1;
        b_q.push_back(bt);
        b_base  = 4'd8;
        b_len   = 4'd1;
        b_start = 1'b1;
        step();
        b_start   = 1'b0;
        a_req     = 1'b1;
        a_we      = 1'b1;
        a_addr    = 4'd8;
        a_lane_en = 8'hFF;
        a_wdata   = '1;
        step();
        a_req = 1'b0;
        a_we  = 1'b0;
        wait_idle(cyc);
        check("fwd_beats_left", DW'(b_q.size()), DW'(0));
        rd(8, '1);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
